// File: rtl/i2c_poll_arbiter.sv
// rtl/i2c_poll_arbiter.sv - shares one i2c master engine between a host port and a periodic register poller
module i2c_poll_arbiter #(
  parameter int NREG    = 2,
  parameter int PERIOD  = 1000000,
  parameter int TIMEOUT = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [6:0]        host_addr,
  input  logic [7:0]        host_reg,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic              host_done,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              host_timeout,
  input  logic              poll_en,
  input  logic [6:0]        poll_addr,
  input  logic [7:0]        poll_base_reg,
  output logic [8*NREG-1:0] poll_data,
  output logic [NREG-1:0]   poll_err,
  output logic              poll_frame,
  output logic              poll_overrun,
  output logic              eng_start,
  output logic              eng_rw,
  output logic [6:0]        eng_slave_address,
  output logic [7:0]        eng_slave_reg,
  output logic [7:0]        eng_tx_data,
  input  logic              eng_done,
  input  logic              eng_ack,
  input  logic              eng_busy,
  input  logic [7:0]        eng_rx_data
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] tick_cnt;
  logic [TW-1:0] to_cnt;
  logic [IW-1:0] poll_idx;
  logic          poll_pending;
  logic          owner_host;
  logic          last_grant_host;
  logic          tick, poll_cand, grant_any, grant_host, to_hit, xfer_ack, last_slot;

  // Grants wait for the engine to drop busy so it always finishes its stop condition first.
  always_comb begin
    tick       = poll_en && (tick_cnt == CW'(PERIOD - 1));
    poll_cand  = poll_pending && poll_en;
    grant_any  = !eng_busy && (host_req || poll_cand);
    grant_host = !eng_busy && host_req && (!poll_cand || !last_grant_host);
    to_hit     = (to_cnt == TW'(TIMEOUT - 1));
    xfer_ack   = eng_done && eng_ack;
    last_slot  = (poll_idx == IW'(NREG - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (eng_done || to_hit) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Reset forces the engine strobe inactive immediately, not one cycle later.
  always_comb begin
    eng_start  = reset || !(state == ISSUE || state == WAIT);
    host_gnt   = !reset && (state == IDLE) && grant_host;
    host_done  = !reset && (state == FINISH) && owner_host;
    poll_frame = !reset && (state == FINISH) && !owner_host && last_slot && poll_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt          <= '0;
      to_cnt            <= '0;
      poll_idx          <= '0;
      poll_pending      <= 1'b0;
      owner_host        <= 1'b0;
      last_grant_host   <= 1'b0;
      host_ack          <= 1'b0;
      host_rdata        <= 8'h00;
      host_timeout      <= 1'b0;
      poll_data         <= '0;
      poll_err          <= '0;
      poll_overrun      <= 1'b0;
      eng_rw            <= 1'b0;
      eng_slave_address <= 7'h00;
      eng_slave_reg     <= 8'h00;
      eng_tx_data       <= 8'h00;
    end else begin
      if (!poll_en || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
      end

      if (tick) begin
        if (poll_pending) begin
          poll_overrun <= 1'b1;
        end else begin
          poll_pending <= 1'b1;
          poll_idx     <= '0;
        end
      end

      // A disabled poller abandons its frame unless it currently owns the engine.
      if (!poll_en && (state == IDLE || owner_host)) begin
        poll_pending <= 1'b0;
        poll_idx     <= '0;
      end

      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_host      <= grant_host;
            last_grant_host <= grant_host;
            if (grant_host) begin
              host_timeout      <= 1'b0;
              eng_rw            <= host_rw;
              eng_slave_address <= host_addr;
              eng_slave_reg     <= host_reg;
              eng_tx_data       <= host_wdata;
            end else begin
              eng_rw            <= 1'b0;
              eng_slave_address <= poll_addr;
              eng_slave_reg     <= poll_base_reg + 8'(poll_idx);
              eng_tx_data       <= 8'h00;
            end
          end
        end
        ISSUE: begin
          to_cnt <= '0;
        end
        WAIT: begin
          to_cnt <= to_cnt + TW'(1);
          // Results land on the exit edge so they are valid alongside host_done/poll_frame.
          if (eng_done || to_hit) begin
            if (owner_host) begin
              host_ack <= xfer_ack;
              if (xfer_ack && !eng_rw) host_rdata <= eng_rx_data;
              if (!eng_done) host_timeout <= 1'b1;
            end else begin
              for (int i = 0; i < NREG; i++) begin
                if (poll_idx == IW'(i)) begin
                  if (xfer_ack) begin
                    poll_data[8*i +: 8] <= eng_rx_data;
                    poll_err[i]         <= 1'b0;
                  end else begin
                    poll_err[i] <= 1'b1;
                  end
                end
              end
            end
          end
        end
        FINISH: begin
          if (!owner_host) begin
            if (!poll_en || last_slot) begin
              poll_pending <= 1'b0;
              poll_idx     <= '0;
            end else begin
              poll_idx <= poll_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/i2c_poll_arbiter.md
Name: i2c_poll_arbiter

Overview:
Sequencer and arbiter placed in front of the i2c master engine (start/rw/slave_address/slave_reg/i2c_tx_data in; done/ack/i2c_busy/i2c_rx_data out).
It shares the engine between two requesters:
- a host port, driven by the Wishbone/CPU side, for single register transactions;
- an autonomous poller that periodically reads NREG consecutive registers from one sensor and caches the results for the LCD/pH logic.

Parameters:
NREG, 2, number of consecutive registers read per poll frame (1..8)
PERIOD, 1000000, clk cycles between poll frame triggers
TIMEOUT, 2000000, max clk cycles waiting for eng_done before a transaction is aborted

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
host_req  in  1  host transaction request; level, held until host_gnt
host_rw  in  1  1=write, 0=read
host_addr  in  7  slave address
host_reg  in  8  slave register
host_wdata  in  8  write data
host_gnt  out  1  1-cycle pulse: request latched
host_done  out  1  1-cycle pulse: host transaction finished
host_ack  out  1  ack of last host transaction (valid from host_done)
host_rdata  out  8  read data of last host read
host_timeout  out  1  sticky; cleared by next host_gnt
poll_en  in  1  enable periodic polling
poll_addr  in  7  sensor slave address
poll_base_reg  in  8  first register of the frame
poll_data  out  8*NREG  cached bytes; slot i in bits [8i+7:8i]
poll_err  out  NREG  per-slot nack/timeout flag of the last frame
poll_frame  out  1  1-cycle pulse: frame complete
poll_overrun  out  1  sticky; set when a tick arrives while a frame is still pending; cleared by reset only
eng_start  out  1  engine start, ACTIVE LOW
eng_rw  out  1  1=write, 0=read
eng_slave_address  out  7
eng_slave_reg  out  8
eng_tx_data  out  8
eng_done  in  1  engine completion pulse
eng_ack  in  1  engine ack (1=success)
eng_busy  in  1  engine busy
eng_rx_data  in  8  engine read data

Behaviour:
- Reset values:
  - eng_start=1; all other eng_* outputs = 0.
  - host_gnt, host_done, host_ack, host_timeout, poll_frame, poll_overrun = 0; host_rdata = 0.
  - poll_data = 0; poll_err = 0.
  - state=IDLE; tick counter=0; poll_pending=0; poll_idx=0; last_grant=POLL.
- Reset asserted mid-transaction returns to IDLE in the same cycle and drives eng_start=1. The engine's own reset is separate.
- Tick counter:
  - Counts 0..PERIOD-1 only while poll_en=1; held at 0 while poll_en=0.
  - On reaching PERIOD-1 it wraps to 0 and raises a tick.
  - Tick with poll_pending=0: set poll_pending=1, poll_idx=0.
  - Tick with poll_pending=1: set poll_overrun; tick otherwise ignored.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - Candidates are host_req and (poll_pending & poll_en).
  - Only one candidate: grant it.
  - Both candidates: grant the one not equal to last_grant (round-robin).
  - Grant cycle:
    - Latch addr/reg/wdata/rw into the eng_* registers; record owner; update last_grant.
    - Pulse host_gnt if the owner is the host.
    - Poll owner drives rw=0, addr=poll_addr, reg=poll_base_reg+poll_idx (8-bit wrap), tx_data=0.
    - Go to ISSUE.
- ISSUE:
  - eng_start=0 from the cycle after grant.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - eng_start held 0 until eng_done.
  - On eng_done: capture eng_ack and eng_rx_data, set eng_start=1, go to FINISH.
  - If the counter reaches TIMEOUT-1 first: eng_start=1, treat as ack=0, set the timeout flag, go to FINISH.
- FINISH (1 cycle), then IDLE:
  - Host owner: pulse host_done; update host_ack; update host_rdata only for reads with ack=1; set host_timeout if timed out.
  - Poll owner: if ack=1, write rx into slot poll_idx and clear poll_err[poll_idx]; else set poll_err[poll_idx] and keep the old data.
  - Poll owner, poll_idx==NREG-1: clear poll_pending, pulse poll_frame. Otherwise increment poll_idx.
- poll_en dropped mid-frame:
  - The in-flight transaction completes normally.
  - poll_pending is then cleared without a poll_frame pulse; poll_idx resets to 0.
- Latency:
  - host_req to host_gnt: 1 cycle when IDLE and uncontended.
  - host_gnt to eng_start low: 1 cycle.
  - eng_done to host_done/cache update: 1 cycle.
- Minimum idle gap between transactions: 1 cycle, so the engine sees eng_start=1 between starts.

Test Plan:
- Host write: addr=0x48, reg=0x01, wdata=0xA5, rw=1 → gnt 1 cycle after req. eng_start low with eng_rw=1, eng_slave_address=0x48, eng_slave_reg=0x01, eng_tx_data=0xA5. Engine model done/ack=1 → host_done next cycle, host_ack=1.
- Poll frame, NREG=2, PERIOD=100, poll_addr=0x63, base=0xFE, model returns 0x11, 0x22 → reads of regs 0xFE then 0xFF. poll_data={0x22,0x11}, poll_err=0, one poll_frame pulse.
- Contention: host_req asserted on the tick cycle, last_grant=POLL → host served first, then poll slot 0, then slot 1. Host held through a frame gets the slot between slot 0 and slot 1.
- Nack/timeout, TIMEOUT=50: slot 1 model returns ack=0 → poll_err=2'b10 and slot 1 data unchanged. Model with no done → eng_start returns high at cycle 50; host_timeout=1, host_ack=0.
- Overrun and disable: PERIOD=10 with done delayed 30 cycles → poll_overrun=1. poll_en dropped mid-frame → current read finishes, no poll_frame, next IDLE grants host only.
- Reset asserted in WAIT → next cycle eng_start=1, state IDLE, all outputs at reset values.
